magic_packet_ctrl: RTL and testbench

Sequencing controller for the magic-packet scoreboard around a DEPTH-entry FIFO under test. It tracks FIFO occupancy, chooses the capture cycle from a free "arm" input driven by the formal tool, and latches the magic packet's data. It then counts down the packets ahead of the magic packet and flags the exit cycle. At exit it compares the FIFO output against the latched data. It sits beside the FIFO in the verification wrapper; its outputs feed the wrapper's assertions.

---
 rtl/magic_packet_ctrl_if.sv | 22 ++
 rtl/magic_packet_ctrl.sv | 101 ++++++++++
 tb/tb_magic_packet_ctrl.sv | 221 ++++++++++++++++++++++
 3 files changed

// File: rtl/magic_packet_ctrl_if.sv
// FIFO-side signal bundle observed by the magic-packet controller.
// The wrapper drives all signals; the controller only listens.
interface magic_packet_ctrl_if #(
  parameter int WIDTH = 8
);
  logic             push;
  logic             pop;
  logic             full;
  logic             empty;
  logic [WIDTH-1:0] data_in;
  logic [WIDTH-1:0] data_out;

  modport master (
    output push, pop, full, empty,
    output data_in, data_out
  );

  modport slave (
    input push, pop, full, empty,
    input data_in, data_out
  );
endinterface

// File: rtl/magic_packet_ctrl.sv
// Magic-packet scoreboard sequencer: tracks occupancy, captures one
// packet on arm, counts packets ahead of it and checks it on exit.
module magic_packet_ctrl #(
  parameter int DEPTH  = 8,
  parameter int WIDTH  = 8,
  parameter int CNTWID = $clog2(DEPTH) + 1
) (
  input  logic              clk,
  input  logic              rst,
  magic_packet_ctrl_if.slave fifo,
  input  logic              arm,
  output logic [1:0]        state,
  output logic              captured,
  output logic [CNTWID-1:0] cnt,
  output logic [CNTWID-1:0] next_cnt,
  output logic [WIDTH-1:0]  magic_data,
  output logic              exiting,
  output logic              mismatch,
  output logic              done
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] TRACK = 2'd1;
  localparam logic [1:0] DONE  = 2'd2;

  localparam logic [CNTWID-1:0] ONE  = CNTWID'(1);
  localparam logic [CNTWID-1:0] ZERO = '0;
  localparam logic [CNTWID-1:0] CMAX = CNTWID'(DEPTH);

  logic       wr;
  logic       rd;
  logic       capture;
  logic [1:0] next_state;

  assign wr = fifo.push & ~fifo.full;
  assign rd = fifo.pop & ~fifo.empty;

  always_comb begin
    next_state = state;
    next_cnt   = cnt;
    exiting    = 1'b0;
    capture    = 1'b0;
    if (rst) begin
      next_state = IDLE;
      next_cnt   = ZERO;
    end else begin
      case (state)
        IDLE: begin
          if (arm && wr) begin
            // the captured packet itself is never counted
            capture    = 1'b1;
            next_state = TRACK;
            if (rd && cnt != ZERO)
              next_cnt = cnt - ONE;
          end else if (wr && !rd) begin
            if (cnt != CMAX)
              next_cnt = cnt + ONE;
          end else if (rd && !wr) begin
            if (cnt != ZERO)
              next_cnt = cnt - ONE;
          end
        end
        TRACK: begin
          if (rd) begin
            if (cnt == ZERO) begin
              exiting    = 1'b1;
              next_state = DONE;
            end else begin
              next_cnt = cnt - ONE;
            end
          end
        end
        DONE: begin
          next_state = DONE;
        end
        default: begin
          next_state = IDLE;
          next_cnt   = ZERO;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    state <= next_state;
    cnt   <= next_cnt;
    if (rst) begin
      magic_data <= '0;
      mismatch   <= 1'b0;
    end else begin
      if (capture)
        magic_data <= fifo.data_in;
      if (exiting && fifo.data_out != magic_data)
        mismatch <= 1'b1;
    end
  end

  assign captured = (state != IDLE);
  assign done     = (state == DONE);

endmodule

// File: tb/tb_magic_packet_ctrl.sv
// Scoreboard bench for magic_packet_ctrl: a behavioural model predicts
// each cycle's outcome, queued at drive time and checked after the edge.
module tb_magic_packet_ctrl;

  localparam int DEPTH = 8;
  localparam int WIDTH = 8;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic             clk = 1'b0;
  logic             rst;
  logic             arm;
  logic [1:0]       state;
  logic             captured;
  logic [CW-1:0]    cnt;
  logic [CW-1:0]    next_cnt;
  logic [WIDTH-1:0] magic_data;
  logic             exiting;
  logic             mismatch;
  logic             done;

  magic_packet_ctrl_if #(.WIDTH(WIDTH)) fifo ();

  magic_packet_ctrl #(
    .DEPTH(DEPTH),
    .WIDTH(WIDTH)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .fifo      (fifo),
    .arm       (arm),
    .state     (state),
    .captured  (captured),
    .cnt       (cnt),
    .next_cnt  (next_cnt),
    .magic_data(magic_data),
    .exiting   (exiting),
    .mismatch  (mismatch),
    .done      (done)
  );

  always #5 clk = ~clk;

  typedef struct {
    int st;
    int cnt;
    int mag;
    int mis;
  } exp_t;

  exp_t q[$];

  int errs   = 0;
  int checks = 0;

  int m_st  = 0;
  int m_cnt = 0;
  int m_mag = 0;
  int m_mis = 0;

  task automatic chk(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
    end
  endtask

  task automatic step(
    input bit rs, input bit ps, input bit pp,
    input bit fl, input bit em, input bit ar,
    input int di, input int dout
  );
    bit   w, r, ex;
    int   n_st, n_cnt, n_mag, n_mis;
    exp_t e;
    exp_t g;
    @(negedge clk);
    rst           = rs;
    fifo.push     = ps;
    fifo.pop      = pp;
    fifo.full     = fl;
    fifo.empty    = em;
    arm           = ar;
    fifo.data_in  = di[WIDTH-1:0];
    fifo.data_out = dout[WIDTH-1:0];
    w  = ps && !fl;
    r  = pp && !em;
    ex = 0;
    n_st = m_st; n_cnt = m_cnt; n_mag = m_mag; n_mis = m_mis;
    if (rs) begin
      n_st = 0; n_cnt = 0; n_mag = 0; n_mis = 0;
    end else if (m_st == 0) begin
      if (ar && w) begin
        n_st  = 1;
        n_mag = di;
        n_cnt = m_cnt - (r ? 1 : 0);
      end else begin
        n_cnt = m_cnt + (w ? 1 : 0) - (r ? 1 : 0);
      end
      if (n_cnt > DEPTH) n_cnt = DEPTH;
      if (n_cnt < 0) n_cnt = 0;
    end else if (m_st == 1 && r) begin
      if (m_cnt == 0) begin
        ex   = 1;
        n_st = 2;
        if (dout != m_mag) n_mis = 1;
      end else begin
        n_cnt = m_cnt - 1;
      end
    end
    #1;
    chk("exiting", int'(exiting), int'(ex));
    chk("next_cnt", int'(next_cnt), n_cnt);
    e.st = n_st; e.cnt = n_cnt; e.mag = n_mag; e.mis = n_mis;
    q.push_back(e);
    m_st = n_st; m_cnt = n_cnt; m_mag = n_mag; m_mis = n_mis;
    @(posedge clk);
    #1;
    if (q.size() == 0) begin
      chk("queue_empty", 0, 1);
    end else begin
      g = q.pop_front();
      chk("state", int'(state), g.st);
      chk("cnt", int'(cnt), g.cnt);
      chk("magic_data", int'(magic_data), g.mag);
      chk("mismatch", int'(mismatch), g.mis);
      chk("captured", int'(captured), int'(g.st != 0));
      chk("done", int'(done), int'(g.st == 2));
    end
  endtask

  task automatic do_rst();
    step(1, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic do_wr(input bit ar, input int di);
    step(0, 1, 0, 0, 0, ar, di, 0);
  endtask

  task automatic do_rd(input int dout);
    step(0, 0, 1, 0, 0, 0, 0, dout);
  endtask

  task automatic do_idle();
    step(0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    rst = 1; arm = 0;
    fifo.push = 0; fifo.pop = 0;
    fifo.full = 0; fifo.empty = 0;
    fifo.data_in = '0; fifo.data_out = '0;

    do_rst();
    chk("reset_state", int'(state), 0);
    chk("reset_cnt", int'(cnt), 0);

    for (int i = 0; i < 3; i++) do_wr(0, 8'h11 + i);
    chk("occ3", int'(cnt), 3);
    do_rst();

    // good exit
    do_wr(0, 1); do_wr(0, 2);
    do_wr(1, 8'hA5);
    chk("trk_cnt2", int'(cnt), 2);
    do_rd(1); do_rd(2);
    do_rd(8'hA5);
    do_idle();
    chk("done_ok", int'(done), 1);
    chk("no_mis", int'(mismatch), 0);

    // bad exit, sticky mismatch
    do_rst();
    do_wr(0, 1); do_wr(0, 2);
    do_wr(1, 8'hA5);
    do_rd(1); do_rd(2);
    do_rd(8'h5A);
    for (int i = 0; i < 5; i++) do_idle();
    chk("mis_sticky", int'(mismatch), 1);
    do_rst();
    chk("mis_clr", int'(mismatch), 0);

    // capture with simultaneous read
    for (int i = 0; i < 3; i++) do_wr(0, i);
    step(0, 1, 1, 0, 0, 1, 8'h77, 0);
    chk("cap_rd_cnt", int'(cnt), 2);
    for (int i = 0; i < 4; i++) do_wr(0, 8'h40 + i);
    chk("trk_wr_hold", int'(cnt), 2);
    do_rd(0); do_rd(1);
    step(0, 0, 1, 0, 1, 0, 0, 8'h77);
    chk("empty_pop_trk", int'(state), 1);
    do_rd(8'h77);

    // full blocks capture; saturation
    do_rst();
    step(0, 1, 0, 1, 0, 1, 8'h99, 0);
    chk("full_nocap", int'(state), 0);
    for (int i = 0; i < 9; i++) do_wr(0, i);
    chk("sat8", int'(cnt), 8);
    step(0, 1, 1, 0, 0, 0, 0, 0);
    for (int i = 0; i < 10; i++) do_rd(0);
    chk("floor0", int'(cnt), 0);

    // abort mid-track, recapture
    do_rst();
    for (int i = 0; i < 4; i++) do_wr(0, i);
    do_wr(1, 8'hEE);
    chk("trk_cnt4", int'(cnt), 4);
    do_rst();
    chk("abort_idle", int'(state), 0);
    do_wr(1, 8'h3C);
    chk("recap", int'(magic_data), 8'h3C);
    do_rd(8'h3C);
    do_idle();

    if (q.size() != 0) chk("queue_drained", q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
